// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: both cache request ports and the shared data-memory bus.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256
);
  logic              p0_enable_i, p1_enable_i;
  logic              p0_write_i, p1_write_i;
  logic [ADDR_W-1:0] p0_addr_i, p1_addr_i;
  logic [DATA_W-1:0] p0_data_i, p1_data_i;
  logic              p0_ack_o, p1_ack_o;
  logic [DATA_W-1:0] p0_data_o, p1_data_o;
  logic              mem_enable_o, mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic [DATA_W-1:0] mem_data_i;
  logic              mem_ack_i;
  modport slave (
    input  p0_enable_i, p1_enable_i, p0_write_i, p1_write_i,
           p0_addr_i, p1_addr_i, p0_data_i, p1_data_i, mem_data_i, mem_ack_i,
    output p0_ack_o, p1_ack_o, p0_data_o, p1_data_o,
           mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );
  modport master (
    output p0_enable_i, p1_enable_i, p0_write_i, p1_write_i,
           p0_addr_i, p1_addr_i, p0_data_i, p1_data_i, mem_data_i, mem_ack_i,
    input  p0_ack_o, p1_ack_o, p0_data_o, p1_data_o,
           mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter of icache/dcache onto one data memory,
// with a registered request, owner-only ack routing and a BUSY watchdog.
module dmem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 256,
  parameter int TIMEOUT = 1023
) (
  input  logic           clk_i,
  input  logic           rst_i,
  dmem_arbiter_if.slave  bus,
  output logic           err_o
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO = CW'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_e;
  state_e            state_q, state_d;
  logic              grant_q, grant_d, last_q, last_d;
  logic              en_q, en_d, wr_q, wr_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sel, busy_ack;
  // On a tie the port that was not served last wins
  assign sel = (bus.p0_enable_i & bus.p1_enable_i) ? ~last_q : bus.p1_enable_i;
  assign busy_ack = (state_q == BUSY) & bus.mem_ack_i;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    en_d    = en_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (bus.p0_enable_i | bus.p1_enable_i) begin
        state_d = BUSY;
        grant_d = sel;
        en_d    = 1'b1;
        wr_d    = sel ? bus.p1_write_i : bus.p0_write_i;
        addr_d  = sel ? bus.p1_addr_i : bus.p0_addr_i;
        data_d  = sel ? bus.p1_data_i : bus.p0_data_i;
        cnt_d   = '0;
      end
      BUSY: if (bus.mem_ack_i) begin
        state_d = GAP;
        last_d  = grant_q;
        en_d    = 1'b0;
      end else if (TIMEOUT != 0) begin
        cnt_d = (cnt_q == TO) ? cnt_q : cnt_q + 1'b1;
        err_d = err_q | (cnt_d == TO);
      end
      GAP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      en_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      en_q    <= en_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
  assign bus.mem_enable_o = en_q;
  assign bus.mem_write_o  = wr_q;
  assign bus.mem_addr_o   = addr_q;
  assign bus.mem_data_o   = data_q;
  assign bus.p0_ack_o     = busy_ack & ~grant_q;
  assign bus.p1_ack_o     = busy_ack & grant_q;
  assign bus.p0_data_o    = bus.mem_data_i;
  assign bus.p1_data_o    = bus.mem_data_i;
  assign err_o            = err_q;
endmodule
